unified_mem_arbiter: RTL and testbench

- Shares the single-port unified instruction/data memory between two requesters:
  - m0: the multicycle core's fetch/load/store path.
  - m1: the debug/program loader.
- Sequences each access through a small FSM:
  - latches the request;
  - issues it to memory for exactly one cycle;
  - waits out the memory read latency;
  - returns read data with a one-cycle valid pulse.
- Contention is resolved round-robin.

---
 rtl/unified_mem_arbiter.sv | 143 ++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : unified_mem_arbiter
// Description : Round-robin arbiter sharing one single-port unified memory
//               between the core (m0) and the debug loader (m1).
// Revision    : 1.0 - initial release
// ============================================================================
module unified_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_WAIT  = 2'd2;
    localparam logic [1:0] c_RESP  = 2'd3;
    localparam int         c_CNT_W = 4;

    logic [1:0]         state_q, state_d;
    logic               rr_q, rr_d;       // 0: m0 has priority, 1: m1 has priority
    logic               owner_q, owner_d; // 0: m0, 1: m1
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [c_CNT_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0]  m0_rdata_q, m0_rdata_d;
    logic [DATA_W-1:0]  m1_rdata_q, m1_rdata_d;
    logic               w_win_m1;

    assign w_win_m1 = m1_req & (~m0_req | rr_q);

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        m0_rdata_d = m0_rdata_q;
        m1_rdata_d = m1_rdata_q;
        case (state_q)
            c_IDLE: begin
                if (m0_req | m1_req) begin
                    owner_d = w_win_m1;
                    rr_d    = ~w_win_m1;
                    we_d    = w_win_m1 ? m1_we    : m0_we;
                    addr_d  = w_win_m1 ? m1_addr  : m0_addr;
                    wdata_d = w_win_m1 ? m1_wdata : m0_wdata;
                    state_d = c_ISSUE;
                end
            end
            c_ISSUE: begin
                if (we_q) begin
                    state_d = c_IDLE;
                end else begin
                    cnt_d   = c_CNT_W'(MEM_LAT - 1);
                    state_d = c_WAIT;
                end
            end
            c_WAIT: begin
                // Counter reaches zero in the cycle memory presents the data
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - c_CNT_W'(1);
                end else begin
                    if (owner_q) begin
                        m1_rdata_d = mem_rdata;
                    end else begin
                        m0_rdata_d = mem_rdata;
                    end
                    state_d = c_RESP;
                end
            end
            c_RESP: begin
                state_d = c_IDLE;
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= c_IDLE;
            rr_q       <= 1'b0;
            owner_q    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
        end
    end

    // Every output is a decode of registered state; nothing flows from inputs
    assign mem_en    = (state_q == c_ISSUE);
    assign mem_we    = mem_en & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign m0_gnt    = mem_en & ~owner_q;
    assign m1_gnt    = mem_en &  owner_q;
    assign m0_rvalid = (state_q == c_RESP) & ~owner_q;
    assign m1_rvalid = (state_q == c_RESP) &  owner_q;
    assign m0_rdata  = m0_rdata_q;
    assign m1_rdata  = m1_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_unified_mem_arbiter
// Description : Scoreboard bench for unified_mem_arbiter with a transaction-
//               level reference model and a latency-accurate memory stub.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_unified_mem_arbiter;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] dflt(input int idx);
        return (32'(idx) * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
    endfunction

    // Memory stub: data appears LAT cycles after the mem_en cycle, junk otherwise
    logic [31:0] env_mem [256];
    logic [31:0] pipe [LAT];
    assign mem_rdata = pipe[LAT-1];

    always @(posedge clk) begin
        if (mem_en && mem_we) env_mem[mem_addr[9:2]] <= mem_wdata;
        pipe[0] <= (mem_en && !mem_we) ? env_mem[mem_addr[9:2]] : $urandom;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end

    // Reference model: memory image, round-robin history, bus occupancy
    logic [31:0] ref_mem [256];
    typedef struct { logic [31:0] d; int due; } exp_t;
    exp_t q0[$];
    exp_t q1[$];
    logic [31:0] hold0 = 0, hold1 = 0;
    int   last_win  = 1;
    int   next_free = 0;
    bit   in_reset  = 1'b1;

    initial begin
        for (int i = 0; i < 256; i++) begin
            env_mem[i] = dflt(i);
            ref_mem[i] = dflt(i);
        end
        env_mem[16] = 32'hDEAD_BEEF;
        ref_mem[16] = 32'hDEAD_BEEF;
        for (int i = 0; i < LAT; i++) pipe[i] = '0;
    end

    initial begin : monitor
        logic        s_req [2];
        logic        s_we  [2];
        logic [31:0] s_addr[2];
        logic [31:0] s_wd  [2];
        bit          exp_any;
        int          w;
        exp_t        e;
        forever begin
            @(posedge clk);
            cyc++;
            s_req[0] = m0_req; s_we[0] = m0_we; s_addr[0] = m0_addr; s_wd[0] = m0_wdata;
            s_req[1] = m1_req; s_we[1] = m1_we; s_addr[1] = m1_addr; s_wd[1] = m1_wdata;
            #1;
            if (reset) begin
                chk("rst_ctl", 32'({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_en, mem_we}), 0);
                chk("rst_mem_addr", mem_addr, 0);
                chk("rst_mem_wdata", mem_wdata, 0);
                chk("rst_m0_rdata", m0_rdata, 0);
                chk("rst_m1_rdata", m1_rdata, 0);
                q0.delete(); q1.delete();
                hold0 = 0; hold1 = 0; last_win = 1; in_reset = 1'b1;
            end else begin
                if (in_reset) begin
                    in_reset  = 1'b0;
                    next_free = cyc;
                end
                exp_any = (cyc >= next_free) && (s_req[0] || s_req[1]);
                w = (s_req[0] && s_req[1]) ? 1 - last_win : (s_req[1] ? 1 : 0);
                chk("m0_gnt", 32'(m0_gnt), 32'(exp_any && w == 0));
                chk("m1_gnt", 32'(m1_gnt), 32'(exp_any && w == 1));
                chk("mem_en", 32'(mem_en), 32'(exp_any));
                if (exp_any) begin
                    last_win = w;
                    chk("mem_addr", mem_addr, s_addr[w]);
                    chk("mem_we", 32'(mem_we), 32'(s_we[w]));
                    if (s_we[w]) begin
                        chk("mem_wdata", mem_wdata, s_wd[w]);
                        ref_mem[s_addr[w][9:2]] = s_wd[w];
                        next_free = cyc + 2;
                    end else begin
                        e.d   = ref_mem[s_addr[w][9:2]];
                        e.due = cyc + 1 + LAT;
                        if (w == 0) q0.push_back(e); else q1.push_back(e);
                        next_free = cyc + 3 + LAT;
                    end
                end
                if (m0_rvalid) begin
                    if (q0.size() == 0) chk("m0_rvalid_unexpected", 1, 0);
                    else begin
                        e = q0.pop_front();
                        chk("m0_rvalid_cycle", 32'(cyc), 32'(e.due));
                        chk("m0_rdata", m0_rdata, e.d);
                        hold0 = e.d;
                    end
                end else begin
                    if (q0.size() != 0 && q0[0].due <= cyc) begin
                        chk("m0_rvalid_missing", 0, 1);
                        void'(q0.pop_front());
                    end
                    chk("m0_rdata_hold", m0_rdata, hold0);
                end
                if (m1_rvalid) begin
                    if (q1.size() == 0) chk("m1_rvalid_unexpected", 1, 0);
                    else begin
                        e = q1.pop_front();
                        chk("m1_rvalid_cycle", 32'(cyc), 32'(e.due));
                        chk("m1_rdata", m1_rdata, e.d);
                        hold1 = e.d;
                    end
                end else begin
                    if (q1.size() != 0 && q1[0].due <= cyc) begin
                        chk("m1_rvalid_missing", 0, 1);
                        void'(q1.pop_front());
                    end
                    chk("m1_rdata_hold", m1_rdata, hold1);
                end
            end
        end
    end

    task automatic drive(input int id, input logic rq, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
        if (id == 0) begin
            m0_req = rq; m0_we = w; m0_addr = a; m0_wdata = d;
        end else begin
            m1_req = rq; m1_we = w; m1_addr = a; m1_wdata = d;
        end
    endtask

    // Waits (bounded) for this master's grant; n = negedges waited
    task automatic wait_gnt(input int id, output int n);
        bit got = 1'b0;
        n = 0;
        for (int k = 1; k <= 40 && !got; k++) begin
            @(negedge clk);
            if ((id == 0) ? m0_gnt : m1_gnt) begin
                got = 1'b1;
                n   = k;
            end
        end
        chk((id == 0) ? "m0_gnt_seen" : "m1_gnt_seen", 32'(got), 1);
    endtask

    task automatic run_master(input int id, input int n_txn);
        int          d, n;
        logic        w;
        logic [31:0] a;
        for (int k = 0; k < n_txn; k++) begin
            d = $urandom_range(0, 2);
            if (d != 0) begin
                drive(id, 1'b0, 1'b0, 32'h0, 32'h0);
                repeat (d) @(negedge clk);
            end
            w = ($urandom_range(0, 2) == 0);
            a = 32'h100 + 32'(4 * $urandom_range(0, 7));
            drive(id, 1'b1, w, a, $urandom);
            wait_gnt(id, n);
            @(negedge clk);
        end
        drive(id, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin : stimulus
        int n, cnt;
        int ord[8];
        bit drop0, drop1;
        reset = 1'b1;
        drive(0, 1'b1, 1'b0, 32'h40, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) @(negedge clk);
        chk("reset_outputs", 32'({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_en, mem_we}), 0);

        // Read out of reset, DEADBEEF preloaded at 0x40
        reset = 1'b0;
        wait_gnt(0, n);
        chk("first_issue_delay", 32'(n), 1);
        chk("first_issue_en", 32'(mem_en), 1);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (LAT - 1) @(negedge clk);
        chk("read_early_rvalid", 32'(m0_rvalid), 0);
        @(negedge clk);
        chk("read_rvalid", 32'(m0_rvalid), 1);
        chk("read_rdata", m0_rdata, 32'hDEAD_BEEF);
        chk("read_other_rdata", m1_rdata, 0);

        // Loader write
        @(negedge clk);
        drive(1, 1'b1, 1'b1, 32'h100, 32'h1234_5678);
        wait_gnt(1, n);
        chk("wr_mem_we", 32'(mem_we), 1);
        chk("wr_mem_addr", mem_addr, 32'h100);
        chk("wr_mem_wdata", mem_wdata, 32'h1234_5678);
        chk("wr_m0_gnt", 32'(m0_gnt), 0);
        @(negedge clk);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (4) @(negedge clk);

        // Contention from reset: alternating grants
        reset = 1'b1;
        drive(0, 1'b1, 1'b0, 32'h104, 32'h0);
        drive(1, 1'b1, 1'b0, 32'h100, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        cnt = 0; drop0 = 1'b0; drop1 = 1'b0;
        for (int k = 0; k < 80 && (m0_req || m1_req); k++) begin
            @(negedge clk);
            if (drop0) m0_req = 1'b0;
            if (drop1) m1_req = 1'b0;
            if (m0_gnt && cnt < 8) begin ord[cnt] = 0; cnt++; if (cnt >= 4) drop0 = 1'b1; end
            if (m1_gnt && cnt < 8) begin ord[cnt] = 1; cnt++; if (cnt >= 4) drop1 = 1'b1; end
        end
        chk("rr_grant_count", 32'(cnt >= 4), 1);
        for (int i = 0; i < 4; i++) chk("rr_order", 32'(ord[i]), 32'(i % 2));
        repeat (8) @(negedge clk);

        // Reset in the WAIT phase of an m0 read, m1 pending
        drive(0, 1'b1, 1'b0, 32'h44, 32'h0);
        wait_gnt(0, n);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b1, 1'b0, 32'h10C, 32'h0);
        reset = 1'b1;
        #1;
        chk("midrst_ctl", 32'({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_en, mem_we}), 0);
        chk("midrst_addr", mem_addr, 0);
        chk("midrst_rdata", m0_rdata | m1_rdata, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        wait_gnt(1, n);
        chk("midrst_m1_first", 32'(n), 1);
        @(negedge clk);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("midrst_no_m0_rvalid", 32'(m0_rvalid), 0);
        end

        // Randomized concurrent traffic
        fork
            run_master(0, 60);
            run_master(1, 60);
        join
        repeat (20) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
